// File: rtl/lcb_pkg.sv
// Shared definitions for the LCB responder.
//   lcb_state_e : responder FSM states
//   LCB_SYNC    : default sync byte that leads request and response frames
//   CYC_W       : width of the cycle-number field carried in byte 1
package lcb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_TURN,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GUARD
  } lcb_state_e;

  localparam logic [7:0] LCB_SYNC = 8'hA5;
  localparam int         CYC_W    = 5;

endpackage

// File: rtl/lcb_uart_tx_byte.sv
// 8N1 byte serialiser, LSB first, CLK_DIV clock cycles per bit.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start_i    : load data_i and begin a byte; honoured only while ready_o=1
//   data_i     : byte to send
//   ready_o    : high when idle and during the final cycle of the stop bit, so
//                a start in that cycle chains the next byte with no idle gap
//   tx_o       : serial line, idles high
module lcb_uart_tx_byte #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             act_q, act_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [9:0]       sr_q, sr_d;

  assign ready_o = !act_q || (bit_q == 4'd9 && div_q == DIV_LAST);
  assign tx_o    = act_q ? sr_q[0] : 1'b1;

  always_comb begin
    act_d = act_q;
    div_d = div_q;
    bit_d = bit_q;
    sr_d  = sr_q;
    if (start_i && ready_o) begin
      act_d = 1'b1;
      div_d = '0;
      bit_d = 4'd0;
      // frame = {stop, data, start}, shifted out from bit 0
      sr_d  = {1'b1, data_i, 1'b0};
    end else if (act_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (bit_q == 4'd9) begin
          act_d = 1'b0;
        end else begin
          bit_d = bit_q + 4'd1;
          sr_d  = {1'b1, sr_q[9:1]};
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q <= 1'b0;
      div_q <= '0;
      bit_q <= 4'd0;
    end else begin
      act_q <= act_d;
      div_q <= div_d;
      bit_q <= bit_d;
    end
  end

  // shift data needs no reset: tx_o is forced high whenever act_q is low
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

endmodule

// File: rtl/lcb_responder.sv
// LCB-side responder for the RS-485 request/response link.
// Takes a request frame byte-by-byte from a UART RX, validates sync and XOR
// checksum, waits a turnaround gap, then sends a response frame (8N1) built
// from sync, cycle number, payload ROM bytes and checksum.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   rxData, rxValid  : received byte; one byte per rising edge of rxValid
//   rspAddr, rspData : payload ROM port (1-cycle read latency)
//   tx               : serial output, idles high
//   dirTX, dirRX     : RS-485 driver enable / receiver disable (identical)
//   cycleNum         : cycle field of the last accepted request
//   busy             : high outside IDLE and RECV
//   frameErr         : 1-cycle pulse on bad checksum or inter-byte timeout
module lcb_responder
  import lcb_pkg::*;
#(
  parameter int         REQ_BYTES  = 14,
  parameter int         RSP_BYTES  = 16,
  parameter logic [7:0] SYNC       = LCB_SYNC,
  parameter int         CLK_DIV    = 16,
  parameter int         TURNAROUND = 64,
  parameter int         GUARD      = 32,
  parameter int         TIMEOUT    = 400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rxData,
  input  logic             rxValid,
  output logic [4:0]       rspAddr,
  input  logic [7:0]       rspData,
  output logic             tx,
  output logic             dirTX,
  output logic             dirRX,
  output logic [CYC_W-1:0] cycleNum,
  output logic             busy,
  output logic             frameErr
);

  if (REQ_BYTES < 3 || RSP_BYTES < 3) begin : g_bad_len
    $error("lcb_responder: REQ_BYTES and RSP_BYTES must both be at least 3");
  end

  localparam int ADDR_W = 5;
  localparam int MAXB   = (REQ_BYTES > RSP_BYTES) ? REQ_BYTES : RSP_BYTES;
  localparam int IDX_W  = $clog2(MAXB + 1);
  localparam int TM_A   = (TURNAROUND > GUARD) ? TURNAROUND : GUARD;
  localparam int TM_MAX = (TM_A > TIMEOUT) ? TM_A : TIMEOUT;
  localparam int TM_W   = $clog2(TM_MAX + 1);

  localparam logic [IDX_W-1:0] REQ_LAST  = IDX_W'(REQ_BYTES - 1);
  localparam logic [IDX_W-1:0] RSP_LAST  = IDX_W'(RSP_BYTES - 1);
  localparam logic [TM_W-1:0]  TURN_LAST = TM_W'(TURNAROUND - 1);
  localparam logic [TM_W-1:0]  GRD_LAST  = TM_W'(GUARD - 1);
  localparam logic [TM_W-1:0]  TOUT_LAST = TM_W'(TIMEOUT - 1);

  lcb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TM_W-1:0]   tmr_q, tmr_d;
  logic [7:0]        chk_q, chk_d;
  logic [CYC_W-1:0]  cand_q, cand_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic              err_q, err_d;

  logic              rv_q, strb_q;
  logic [7:0]        rxb_q;

  logic              tx_start, tx_ready;
  logic [7:0]        tx_byte;

  assign rspAddr  = addr_q;
  assign dirTX    = dir_q;
  assign dirRX    = dir_q;
  assign cycleNum = cyc_q;
  assign frameErr = err_q;
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_RECV);

  // Rising-edge detector: strb_q is high for one cycle per rxValid assertion,
  // however long rxValid is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv_q   <= 1'b0;
      strb_q <= 1'b0;
    end else begin
      rv_q   <= rxValid;
      strb_q <= rxValid && !rv_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rxValid && !rv_q) rxb_q <= rxData;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_d    = tmr_q;
    chk_d    = chk_q;
    cand_d   = cand_q;
    cyc_d    = cyc_q;
    addr_d   = addr_q;
    dir_d    = dir_q;
    err_d    = 1'b0;
    tx_start = 1'b0;
    tx_byte  = rspData;

    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (strb_q && rxb_q == SYNC) begin
          state_d = ST_RECV;
          idx_d   = IDX_W'(1);
          // checksum covers bytes 1..N-2 only, so the sync byte is not folded in
          chk_d   = 8'h00;
        end
      end

      ST_RECV: begin
        if (strb_q) begin
          tmr_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == REQ_LAST) begin
            if (rxb_q == chk_q) begin
              state_d = ST_TURN;
              cyc_d   = cand_q;
            end else begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end
          end else begin
            chk_d = chk_q ^ rxb_q;
            if (idx_q == IDX_W'(1)) cand_d = rxb_q[CYC_W-1:0];
          end
        end else if (tmr_q == TOUT_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_TURN: begin
        if (tmr_q == TURN_LAST) begin
          state_d = ST_LOAD;
          tmr_d   = '0;
          idx_d   = '0;
          dir_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      // rspAddr is already valid here; ROM data follows in ST_START
      ST_LOAD: state_d = ST_START;

      ST_START: begin
        if (idx_q == '0)           tx_byte = SYNC;
        else if (idx_q == IDX_W'(1)) tx_byte = {{(8 - CYC_W){1'b0}}, cyc_q};
        else if (idx_q == RSP_LAST)  tx_byte = chk_q;
        // Hand over in the serialiser's last stop-bit cycle so bytes abut.
        if (tx_ready) begin
          tx_start = 1'b1;
          if (idx_q == '0)             chk_d = 8'h00;
          else if (idx_q != RSP_LAST)  chk_d = chk_q ^ tx_byte;
          state_d = (idx_q == RSP_LAST) ? ST_STOP : ST_DATA;
        end
      end

      // a byte is in flight; prepare the next one while it shifts out
      ST_DATA: begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_LOAD;
      end

      // last byte in flight; ready rises in its final stop-bit cycle
      ST_STOP: begin
        if (tx_ready) begin
          state_d = ST_GUARD;
          tmr_d   = '0;
        end
      end

      ST_GUARD: begin
        if (tmr_q == GRD_LAST) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
          dir_d   = 1'b0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_LOAD && idx_d >= IDX_W'(2) && idx_d < RSP_LAST)
      addr_d = ADDR_W'(idx_d - IDX_W'(2));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      cyc_q   <= '0;
      addr_q  <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    chk_q  <= chk_d;
    cand_q <= cand_d;
  end

  lcb_uart_tx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .start_i (tx_start),
    .data_i  (tx_byte),
    .ready_o (tx_ready),
    .tx_o    (tx)
  );

endmodule
